// File: rtl/out_port_pkg.sv
// out_port_pkg: shared definitions for the CPU output-port buffer.
//   OUT_DW             default data width of the output port
//   OUT_DEPTH_DEFAULT  default FIFO depth
//   fill_state_e       EMPTY / PARTIAL / FULL view of the occupancy count
//   wrap_inc()         pointer increment modulo an arbitrary depth
package out_port_pkg;

    localparam int OUT_DW            = 8;
    localparam int OUT_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

    // Depth need not be a power of two, so wrap explicitly instead of
    // relying on natural pointer overflow.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/out_port_fifo_mem.sv
// out_port_fifo_mem: DEPTH x DW register array backing the output-port FIFO.
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (asynchronous read)
//   rdata  out  mem[raddr]
// Storage has no reset; contents are only meaningful behind the read pointer
// of an occupied slot.
module out_port_fifo_mem
    import out_port_pkg::*;
#(
    parameter int DW    = OUT_DW,
    parameter int DEPTH = OUT_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_buffer.sv
// out_port_buffer: captures CPU output-port writes in a show-ahead FIFO and
// drains them to an external peripheral over valid/ready.
//   clk, rst         clock (rising) and asynchronous active-high reset
//   out_we/out_data  CPU output write strobe and data
//   O_Port           registered copy of the last accepted CPU write
//   ext_valid        FIFO head available
//   ext_data         FIFO head (show-ahead)
//   ext_ready        peripheral takes the head this cycle
//   stall            backpressure to the CPU (optional feature)
//   count            occupancy, 0..DEPTH
//   overflow         sticky flag: a write was dropped on a full FIFO
//   clr_ovf          synchronous clear of overflow (a new drop wins)
// Build option: define OUT_PORT_STALL_EN to drive stall = full && !ext_ready;
// otherwise stall is tied low and the CPU never waits.
module out_port_buffer
    import out_port_pkg::*;
#(
    parameter int DW    = OUT_DW,
    parameter int DEPTH = OUT_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          out_we,
    input  logic [DW-1:0] out_data,
    output logic [DW-1:0] O_Port,
    output logic          ext_valid,
    output logic [DW-1:0] ext_data,
    input  logic          ext_ready,
    output logic          stall,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] o_port_q, o_port_d;
    logic          overflow_q, overflow_d;

    fill_state_e   fill;
    logic          push, pop, drop;

    always_comb begin
        fill = FILL_PARTIAL;
        if (count_q == '0) begin
            fill = FILL_EMPTY;
        end else if (count_q == CNT_FULL) begin
            fill = FILL_FULL;
        end

        // A pop frees a slot on the same edge, so a full FIFO still takes
        // the write when the peripheral drains in that cycle.
        pop  = (fill != FILL_EMPTY) && ext_ready;
        push = out_we && ((fill != FILL_FULL) || pop);
        drop = out_we && !push;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        o_port_d   = o_port_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = AW'(wrap_inc(32'(wr_ptr_q), DEPTH));
            o_port_d = out_data;
        end
        if (pop) begin
            rd_ptr_d = AW'(wrap_inc(32'(rd_ptr_q), DEPTH));
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a drop is never lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            o_port_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            o_port_q   <= o_port_d;
            overflow_q <= overflow_d;
        end
    end

    out_port_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (out_data),
        .raddr (rd_ptr_q),
        .rdata (ext_data)
    );

    assign O_Port    = o_port_q;
    assign ext_valid = (fill != FILL_EMPTY);
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef OUT_PORT_STALL_EN
    assign stall = (fill == FILL_FULL) && !ext_ready;
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Bench for out_port_buffer: directed table, async-reset check, randomized
// run against a queue model (DEPTH=4), and a DEPTH=3 wrap/overflow sequence.
module tb_out_port_buffer;

    logic       clk, rst;
    logic       out_we, ext_ready, clr_ovf;
    logic [7:0] out_data;
    logic [7:0] o_port, ext_data;
    logic       ext_valid, stall, overflow;
    logic [2:0] count;

    logic       we3, rdy3, clr3;
    logic [7:0] d3, op3, data3;
    logic       vld3, stall3, ovf3;
    logic [2:0] count3;

    int nvec = 0;
    int nerr = 0;

    out_port_buffer #(.DW(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .out_we(out_we), .out_data(out_data),
        .O_Port(o_port), .ext_valid(ext_valid), .ext_data(ext_data),
        .ext_ready(ext_ready), .stall(stall), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    out_port_buffer #(.DW(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .out_we(we3), .out_data(d3),
        .O_Port(op3), .ext_valid(vld3), .ext_data(data3),
        .ext_ready(rdy3), .stall(stall3), .count(count3),
        .overflow(ovf3), .clr_ovf(clr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_stall(input logic full, input logic rdy);
`ifdef OUT_PORT_STALL_EN
        return full && !rdy;
`else
        return 1'b0 & full & rdy;
`endif
    endfunction

    // ---------------- reference model (DEPTH = 4) ----------------
    localparam int MD = 4;
    logic [7:0] q[$];
    logic [7:0] m_op;
    logic       m_ovf;

    task automatic model_reset();
        q.delete();
        m_op  = 8'h00;
        m_ovf = 1'b0;
    endtask

    task automatic mstep(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
        bit do_pop, do_push;
        out_we = we; out_data = d; ext_ready = rdy; clr_ovf = clr;
        #1;
        chk("pre_valid", ext_valid, q.size() != 0);
        if (q.size() != 0) chk("pre_data", ext_data, q[0]);
        chk("pre_stall", stall, exp_stall(q.size() == MD, rdy));
        do_pop  = (q.size() != 0) && rdy;
        do_push = we && ((q.size() < MD) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(d);
            m_op = d;
        end
        if (we && !do_push) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        @(posedge clk); #1;
        chk("count", count, q.size());
        chk("O_Port", o_port, m_op);
        chk("overflow", overflow, m_ovf);
        chk("ext_valid", ext_valid, q.size() != 0);
        if (q.size() != 0) chk("ext_data", ext_data, q[0]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic [2:0] cnt;
        logic [7:0] op;
        logic       vld;
        logic [7:0] hd;
        logic       ovf;
        logic       stl;
    } vec_t;

    vec_t tbl[20];

    initial begin
        rst = 1'b1;
        out_we = 0; out_data = 0; ext_ready = 0; clr_ovf = 0;
        we3 = 0; d3 = 0; rdy3 = 0; clr3 = 0;
        model_reset();

        #2;
        chk("rst_count", count, 0);
        chk("rst_valid", ext_valid, 0);
        chk("rst_O_Port", o_port, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_stall", stall, 0);
        chk("rst_count3", count3, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          we d      rdy clr cnt op    vld hd    ovf stl
        tbl[0]  = '{1, 8'h55, 0, 0, 1, 8'h55, 1, 8'h55, 0, 0};
        tbl[1]  = '{0, 8'h00, 1, 0, 0, 8'h55, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 8'h11, 0, 0, 1, 8'h11, 1, 8'h11, 0, 0};
        tbl[3]  = '{1, 8'h22, 0, 0, 2, 8'h22, 1, 8'h11, 0, 0};
        tbl[4]  = '{1, 8'h33, 0, 0, 3, 8'h33, 1, 8'h11, 0, 0};
        tbl[5]  = '{1, 8'h44, 0, 0, 4, 8'h44, 1, 8'h11, 0, 1};
        tbl[6]  = '{1, 8'h99, 0, 0, 4, 8'h44, 1, 8'h11, 1, 1};
        tbl[7]  = '{1, 8'hAA, 1, 0, 4, 8'hAA, 1, 8'h22, 1, 0};
        tbl[8]  = '{0, 8'h00, 1, 0, 3, 8'hAA, 1, 8'h33, 1, 0};
        tbl[9]  = '{0, 8'h00, 1, 0, 2, 8'hAA, 1, 8'h44, 1, 0};
        tbl[10] = '{0, 8'h00, 1, 0, 1, 8'hAA, 1, 8'hAA, 1, 0};
        tbl[11] = '{0, 8'h00, 1, 0, 0, 8'hAA, 0, 8'h00, 1, 0};
        tbl[12] = '{0, 8'h00, 0, 1, 0, 8'hAA, 0, 8'h00, 0, 0};
        tbl[13] = '{1, 8'h01, 0, 0, 1, 8'h01, 1, 8'h01, 0, 0};
        tbl[14] = '{1, 8'h02, 0, 0, 2, 8'h02, 1, 8'h01, 0, 0};
        tbl[15] = '{1, 8'h03, 0, 0, 3, 8'h03, 1, 8'h01, 0, 0};
        tbl[16] = '{1, 8'h04, 0, 0, 4, 8'h04, 1, 8'h01, 0, 1};
        tbl[17] = '{1, 8'h05, 0, 0, 4, 8'h04, 1, 8'h01, 1, 1};
        tbl[18] = '{1, 8'h06, 0, 1, 4, 8'h04, 1, 8'h01, 1, 1};
        tbl[19] = '{0, 8'h00, 0, 1, 4, 8'h04, 1, 8'h01, 0, 1};

        for (int i = 0; i < 20; i++) begin
            out_we = tbl[i].we; out_data = tbl[i].d;
            ext_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
            @(posedge clk); #1;
            chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("t%0d_O_Port", i), o_port, tbl[i].op);
            chk($sformatf("t%0d_valid", i), ext_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("t%0d_data", i), ext_data, tbl[i].hd);
            chk($sformatf("t%0d_overflow", i), overflow, tbl[i].ovf);
            chk($sformatf("t%0d_stall", i), stall, exp_stall(tbl[i].stl, 1'b0));
        end

        // Mid-stream async reset: outputs must clear before any clock edge.
        out_we = 0; ext_ready = 0; clr_ovf = 0;
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        mstep(1, 8'hC1, 0, 0);
        mstep(1, 8'hC2, 0, 0);
        mstep(1, 8'hC3, 0, 0);
        mstep(1, 8'hC4, 0, 0);
        mstep(1, 8'hC5, 0, 0);
        mstep(0, 8'h00, 1, 0);
        mstep(0, 8'h00, 1, 0);
        out_we = 0; ext_ready = 0;
        chk("pre_rst_count", count, 2);
        rst = 1'b1; #1;
        chk("async_valid", ext_valid, 0);
        chk("async_count", count, 0);
        chk("async_O_Port", o_port, 0);
        chk("async_overflow", overflow, 0);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            mstep($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);
        end

        // DEPTH=3: alternating push/pop, pointers wrap several times.
        for (int i = 1; i <= 10; i++) begin
            we3 = 1; d3 = 8'(i); rdy3 = 0;
            @(posedge clk); #1;
            chk($sformatf("d3_push%0d_valid", i), vld3, 1);
            chk($sformatf("d3_push%0d_data", i), data3, i);
            chk($sformatf("d3_push%0d_count", i), count3, 1);
            we3 = 0; rdy3 = 1;
            @(posedge clk); #1;
            chk($sformatf("d3_pop%0d_count", i), count3, 0);
        end
        rdy3 = 0;
        for (int i = 0; i < 4; i++) begin
            we3 = 1; d3 = 8'hE0 + 8'(i);
            @(posedge clk); #1;
        end
        we3 = 0;
        chk("d3_full_count", count3, 3);
        chk("d3_overflow", ovf3, 1);
        chk("d3_O_Port", op3, 8'hE2);
        chk("d3_stall", stall3, exp_stall(1'b1, 1'b0));
        rdy3 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("d3_drain%0d", i), data3, 8'hE0 + 8'(i));
            @(posedge clk); #1;
        end
        chk("d3_empty", vld3, 0);
        rdy3 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
